// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one alu16 between two valid/ready requesters.
// Each op runs IDLE -> EXEC -> RESP so the ALU's registered zero flag is settled before it is returned.
module alu_arbiter #(
    parameter int         WIDTH   = 16,
    parameter logic [2:0] IDLE_OP = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_y,
    input  logic               alu_zero
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_grant;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_y;
    logic             r_err;
    logic [1:0]       r_rsp_valid;

    logic             w_grant;
    logic             w_accept;
    logic             w_rsp_take;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    always_comb begin
        w_grant    = (&req_valid) ? ~r_last_grant : req_valid[1];
        w_accept   = (r_state == S_IDLE) && (|req_valid);
        w_rsp_take = (r_state == S_RESP) && rsp_ready[r_grant];
        w_op       = w_grant ? req_op[5:3] : req_op[2:0];
        w_a        = w_grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        w_b        = w_grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        req_ready  = 2'b00;
        if (w_accept)
            req_ready[w_grant] = 1'b1;
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_y;
    assign rsp_err   = r_err;
    // An IDLE_OP request never touches the ALU, so its stale flag is bypassed.
    assign rsp_zero  = r_err | alu_zero;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_alu_op     <= IDLE_OP;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_y          <= '0;
            r_err        <= 1'b0;
            r_rsp_valid  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_op == IDLE_OP) begin
                            r_y                  <= '0;
                            r_err                <= 1'b1;
                            r_rsp_valid[w_grant] <= 1'b1;
                            r_state              <= S_RESP;
                        end else begin
                            r_alu_op <= w_op;
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_state  <= S_EXEC;
                        end
                    end
                end
                // alu16 registers its zero flag on this same edge.
                S_EXEC: begin
                    r_y                  <= alu_y;
                    r_err                <= 1'b0;
                    r_alu_op             <= IDLE_OP;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_state              <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu16 and a response scoreboard.
module tb_alu_arbiter;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0]     req_op;
    logic [2*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_y, alu_a, alu_b, alu_y;
    logic           rsp_zero, rsp_err;
    logic           alu_zero = 1'b0;
    logic [2:0]     alu_op;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         id;
        logic [W-1:0] y;
        logic       z;
        logic       e;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.WIDTH(W), .IDLE_OP(3'b111)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a ^ b;
            3'b011:  return a & b;
            3'b100:  return a << b[3:0];
            3'b101:  return a >> b[3:0];
            default: return '0;
        endcase
    endfunction

    // alu16 stand-in: combinational Y, zero flag registered and held on opcode 111.
    assign alu_y = ref_y(alu_op, alu_a, alu_b);
    always @(posedge clk)
        if (alu_op != 3'b111) alu_zero <= (alu_y == '0);

    function automatic logic [1:0] onehot(input int id);
        return (id != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic request(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ey, input logic ez, input logic ee, input bit keep);
        int n;
        exp_t e;
        n = 0;
        req_valid[id]     = 1'b1;
        req_op[3*id +: 3] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
        #1;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'(onehot(id)));
        e.id = id; e.y = ey; e.z = ez; e.e = ee; e.acc = cyc; e.lat = (op == 3'b111) ? 1 : 2;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!keep) req_valid[id] = 1'b0;
        @(negedge clk);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (op != 3'b111) begin
            chk("exec_op", 32'(alu_op), 32'(op));
            chk("exec_a", 32'(alu_a), 32'(a));
        end else begin
            chk("idle_op_park", 32'(alu_op), 32'd7);
        end
    endtask

    task automatic respond(input int hold);
        exp_t e;
        int n;
        n = 0;
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL sb_empty observed=0 expected=nonzero");
            return;
        end
        e = sb.pop_front();
        while (rsp_valid === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("rsp_valid_bit", 32'(rsp_valid), 32'(onehot(e.id)));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = onehot(1 - e.id);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'(onehot(e.id)));
            chk("hold_y", 32'(rsp_y), 32'(e.y));
            chk("hold_zero", 32'(rsp_zero), 32'(e.z));
            chk("hold_alu_op", 32'(alu_op), 32'd7);
        end
        rsp_ready = onehot(e.id);
        #1;
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
        chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd7);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] a, b, y;
        logic [2:0]   op;
        int           g;
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        do_reset();

        // ADD 3+4 on requester 0
        request(0, 3'b000, 16'd3, 16'd4, 16'd7, 1'b0, 1'b0, 1'b0);
        respond(0);

        // SUB 5-5 on requester 1, response held off for 4 cycles
        request(1, 3'b001, 16'd5, 16'd5, 16'd0, 1'b1, 1'b0, 1'b0);
        respond(4);

        // back-to-back: flag must follow the second op
        request(0, 3'b000, 16'hFFFF, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0);
        respond(0);
        request(0, 3'b101, 16'h8000, 16'd15, 16'd1, 1'b0, 1'b0, 1'b0);
        respond(0);

        // IDLE_OP request: error, zero forced, ALU parked
        request(0, 3'b111, 16'h1234, 16'h5678, 16'd0, 1'b1, 1'b1, 1'b0);
        respond(1);

        // opcode 110 passes through without error
        request(1, 3'b110, 16'h00AA, 16'h0055, 16'd0, 1'b1, 1'b0, 1'b0);
        respond(0);

        // reset asserted while in EXEC aborts the op
        req_valid[0] = 1'b1; req_op[2:0] = 3'b000; req_a[W-1:0] = 16'd9; req_b[W-1:0] = 16'd9;
        #1;
        chk("abort_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_exec_op", 32'(alu_op), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_op", 32'(alu_op), 32'd7);
        chk("abort_alu_a", 32'(alu_a), 32'd0);
        chk("abort_rsp_y", 32'(rsp_y), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        request(0, 3'b000, 16'd20, 16'd22, 16'd42, 1'b0, 1'b0, 1'b0);
        respond(0);

        // both requesters always valid: grants alternate starting with 0
        do_reset();
        req_valid = 2'b11;
        req_op    = {3'b100, 3'b010};
        for (int k = 0; k < 20; k++) begin
            g  = k % 2;
            op = (g == 0) ? 3'b010 : 3'b100;
            a  = 16'($urandom);
            b  = (k % 5 == 0) ? a : 16'($urandom);
            if (g == 1 && k % 5 == 0) a = 16'd0;
            y  = ref_y(op, a, b);
            request(g, op, a, b, y, (y == '0), 1'b0, 1'b1);
            respond(k % 3);
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
